// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for a five-stage pipeline.
// A shift-register scoreboard tracks the destination register of each instruction
// past decode. From it, the unit derives operand forwarding selects, the load-use
// stall and the taken-branch flush. It also keeps saturating event counters.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned STAGES       = 3,
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16,
    localparam int unsigned FWD_W       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES) + 1;

    // Scoreboard slots: index 0 is EX, higher indices are older.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] ld_q, ld_d;
    logic [REG_AW-1:0] rd_q [STAGES];
    logic [REG_AW-1:0] rd_d [STAGES];

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic             a_ld, b_ld;
    logic [FWD_W-1:0] a_sel, b_sel;
    logic             load_use;

    // Youngest matching slot for each source; walking old-to-young lets the youngest win.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        a_ld  = 1'b0;
        b_ld  = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (v_q[k] && (rd_q[k] == id_rs) && (id_rs != '0)) begin
                a_sel = FWD_W'(k + 1);
                a_ld  = ld_q[k] && (k < int'(LOAD_LAT));
            end
            if (v_q[k] && (rd_q[k] == id_rt) && (id_rt != '0)) begin
                b_sel = FWD_W'(k + 1);
                b_ld  = ld_q[k] && (k < int'(LOAD_LAT));
            end
        end
    end

    assign load_use    = a_ld | (id_uses_rt & b_ld);
    assign flush       = ex_branch_taken | (fcnt_q != '0);
    assign stall       = id_valid & load_use & ~flush;
    assign fwd_a       = id_valid ? a_sel : '0;
    assign fwd_b       = (id_valid & id_uses_rt) ? b_sel : '0;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    // Next state: shift the scoreboard, run the flush timer, bump the saturating counters.
    always_comb begin
        v_d  = '0;
        ld_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            rd_d[k] = '0;
        end
        // The scoreboard always advances; a held ID stage shows up as a bubble in EX.
        v_d[0]  = id_valid & id_regwrite & (id_rd != '0) & ~stall & ~flush;
        rd_d[0] = id_rd;
        ld_d[0] = id_memread;
        for (int k = 1; k < STAGES; k++) begin
            v_d[k]  = v_q[k-1];
            rd_d[k] = rd_q[k-1];
            ld_d[k] = ld_q[k-1];
        end

        fcnt_d = fcnt_q;
        if (ex_branch_taken) begin
            fcnt_d = FCNT_W'(FLUSH_CYCLES - 1);
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - FCNT_W'(1);
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        flush_count_d = flush_count_q;
        if (ex_branch_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q           <= '0;
            ld_q          <= '0;
            fcnt_q        <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            v_q           <= v_d;
            ld_q          <= ld_d;
            fcnt_q        <= fcnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Register addresses are qualified by v, so they need no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            rd_q[k] <= rd_d[k];
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit, built with FLUSH_CYCLES=2 and CNT_W=2.
// Each row drives the ID/EX inputs and queues the hand-derived hazard outputs for that
// cycle. The outputs are sampled on the falling edge.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_branch_taken;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [1:0] stall_count;
    logic [1:0] flush_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic [5:0] exp;    // {stall, flush, fwd_a, fwd_b}
    } row_t;

    logic [5:0] exp_q[$];

    pipe_hazard_unit #(
        .REG_AW       (5),
        .STAGES       (3),
        .LOAD_LAT     (1),
        .FLUSH_CYCLES (2),
        .CNT_W        (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush           (flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input int r, input int v, input int rs, input int rt,
                                input int ur, input int rd, input int rw, input int mr,
                                input int br, input int st, input int fl, input int fa,
                                input int fb);
        row_t x;
        x.rst = r[0];
        x.v   = v[0];
        x.rs  = rs[4:0];
        x.rt  = rt[4:0];
        x.ur  = ur[0];
        x.rd  = rd[4:0];
        x.rw  = rw[0];
        x.mr  = mr[0];
        x.br  = br[0];
        x.exp = {st[0], fl[0], fa[1:0], fb[1:0]};
        return x;
    endfunction

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic apply_row(input row_t r);
        rst             = r.rst;
        id_valid        = r.v;
        id_rs           = r.rs;
        id_rt           = r.rt;
        id_uses_rt      = r.ur;
        id_rd           = r.rd;
        id_regwrite     = r.rw;
        id_memread      = r.mr;
        ex_branch_taken = r.br;
        exp_q.push_back(r.exp);
    endtask

    task automatic do_reset();
        apply_row(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t       rows[$];
        logic [5:0] got, want;
        apply_row(mk(1, 1, 3, 3, 1, 3, 1, 1, 1, 0, 0, 0, 0));
        void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (stall_count !== 2'd0) begin
            bad++;
            $display("FAIL reset.stall_count got=%0d want=0", stall_count);
        end
        total++;
        if (flush_count !== 2'd0) begin
            bad++;
            $display("FAIL reset.flush_count got=%0d want=0", flush_count);
        end
        rows.push_back(mk(0, 1, 3, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_forward();
        row_t       rows[$];
        logic [5:0] got, want;
        do_reset();
        rows.push_back(mk(0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // ADD r3
        rows.push_back(mk(0, 1, 3, 5, 1, 4, 1, 0, 0, 0, 0, 1, 0));  // SUB r4,r3,r5
        rows.push_back(mk(0, 1, 0, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0));  // writes r7
        rows.push_back(mk(0, 1, 1, 2, 1, 8, 1, 0, 0, 0, 0, 0, 0));  // independent, r8
        rows.push_back(mk(0, 1, 7, 8, 1, 9, 1, 0, 0, 0, 0, 2, 1));  // r7 in MEM, r8 in EX
        rows.push_back(mk(0, 1, 4, 9, 1, 0, 1, 0, 0, 0, 0, 0, 1));  // r4 aged out; writes r0
        rows.push_back(mk(0, 1, 9, 8, 1, 9, 1, 0, 0, 0, 0, 2, 3));  // r8 from WB slot
        rows.push_back(mk(0, 1, 9, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0));  // youngest r9 wins
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL forward[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reg0_unused_rt();
        row_t       rows[$];
        logic [5:0] got, want;
        do_reset();
        rows.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));   // ADDI r0
        rows.push_back(mk(0, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0));   // reads r0
        rows.push_back(mk(0, 1, 1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0));   // rt=r5 unused
        rows.push_back(mk(0, 1, 2, 10, 0, 10, 1, 1, 0, 0, 0, 0, 0)); // LW r10
        rows.push_back(mk(0, 1, 3, 10, 0, 11, 1, 0, 0, 0, 0, 0, 0)); // rt=r10 unused: no stall
        rows.push_back(mk(0, 0, 11, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // id_valid=0
        rows.push_back(mk(0, 1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 2, 0));  // r11 now in MEM
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reg0[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        row_t       rows[$];
        logic [5:0] got, want;
        do_reset();
        rows.push_back(mk(0, 1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0, 0));   // LW r2
        rows.push_back(mk(0, 1, 2, 7, 1, 6, 1, 0, 0, 1, 0, 1, 0));   // ADD r6,r2,r7 stalls
        rows.push_back(mk(0, 1, 2, 7, 1, 6, 1, 0, 0, 0, 0, 2, 0));   // held, now forwards
        rows.push_back(mk(0, 1, 6, 2, 1, 8, 1, 0, 0, 0, 0, 1, 3));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (stall_count !== 2'd1) begin
            bad++;
            $display("FAIL load_use.stall_count got=%0d want=1", stall_count);
        end
        rows.delete();
        rows.push_back(mk(0, 1, 0, 12, 0, 12, 1, 1, 0, 0, 0, 0, 0)); // LW r12
        rows.push_back(mk(0, 1, 1, 12, 1, 13, 1, 0, 0, 1, 0, 0, 1)); // rt load-use
        rows.push_back(mk(0, 1, 1, 12, 1, 13, 1, 0, 0, 0, 0, 0, 2));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_use_rt[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (stall_count !== 2'd2) begin
            bad++;
            $display("FAIL load_use_rt.stall_count got=%0d want=2", stall_count);
        end
    endtask

    task automatic test_flush();
        row_t       rows[$];
        logic [5:0] got, want;
        do_reset();
        rows.push_back(mk(0, 1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));   // LW r4
        rows.push_back(mk(0, 1, 4, 0, 1, 5, 1, 0, 1, 0, 1, 1, 0));   // load-use masked by flush
        rows.push_back(mk(0, 1, 5, 4, 1, 6, 1, 0, 0, 0, 1, 0, 2));   // second flush cycle, EX bubble
        rows.push_back(mk(0, 1, 4, 6, 1, 7, 1, 0, 0, 0, 0, 3, 0));   // both flushed slots empty
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL flush[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (flush_count !== 2'd1) begin
            bad++;
            $display("FAIL flush.flush_count got=%0d want=1", flush_count);
        end
        total++;
        if (stall_count !== 2'd0) begin
            bad++;
            $display("FAIL flush.stall_count got=%0d want=0", stall_count);
        end
        rows.delete();
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));   // back-to-back reload
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));   // counter already saturated
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL back_to_back[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (flush_count !== 2'd3) begin
            bad++;
            $display("FAIL back_to_back.flush_count got=%0d want=3", flush_count);
        end
    endtask

    task automatic test_saturation();
        row_t       rows[$];
        logic [5:0] got, want;
        do_reset();
        rows.push_back(mk(0, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0));   // LW r2,0(r1)
        // LW r2,0(r2) repeatedly: stalls every other cycle, five stalls in total.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) rows.push_back(mk(0, 1, 2, 0, 0, 2, 1, 1, 0, 1, 0, 1, 0));
            else            rows.push_back(mk(0, 1, 2, 0, 0, 2, 1, 1, 0, 0, 0, 2, 0));
        end
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL saturation[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (stall_count !== 2'd3) begin
            bad++;
            $display("FAIL saturation.stall_count got=%0d want=3", stall_count);
        end
    endtask

    task automatic test_reset_mid();
        row_t       rows[$];
        logic [5:0] got, want;
        do_reset();
        rows.push_back(mk(0, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0));   // LW r2
        rows.push_back(mk(1, 1, 2, 7, 1, 6, 1, 0, 0, 1, 0, 1, 0));   // reset during stall
        rows.push_back(mk(0, 1, 2, 7, 1, 6, 1, 0, 0, 0, 0, 0, 0));   // stale r2 gone
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));   // reset during flush
        rows.push_back(mk(0, 1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));   // timer and r6 cleared
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            got  = {stall, flush, fwd_a, fwd_b};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid[%0d] got=%b want=%b", i, got, want);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (stall_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid.stall_count got=%0d want=0", stall_count);
        end
        total++;
        if (flush_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid.flush_count got=%0d want=0", flush_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        id_valid        = 1'b0;
        id_rs           = '0;
        id_rt           = '0;
        id_uses_rt      = 1'b0;
        id_rd           = '0;
        id_regwrite     = 1'b0;
        id_memread      = 1'b0;
        ex_branch_taken = 1'b0;
        test_reset();
        test_forward();
        test_reg0_unused_rt();
        test_load_use();
        test_flush();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
